// File: rtl/pool_2d_stream.sv
// Streaming KxK pooling (max or floor-average), stride K, NFMAPS channels in parallel.
// Latency: one pooled pixel registered the cycle after the window-completing beat.
// Backpressure: in_ready = !out_valid || out_ready; a stalled result freezes all state.
module pool_2d_stream #(
    parameter int NBITS    = 8,
    parameter int NFMAPS   = 4,
    parameter int KER_SIZE = 2,
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NBITS*NFMAPS-1:0] in_act,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NBITS*NFMAPS-1:0] out_act,
    output logic                    out_last
);
    localparam int KK       = KER_SIZE * KER_SIZE;
    localparam int ACC_BITS = NBITS + $clog2(KK);
    localparam int NCOLS    = IMG_W / KER_SIZE;
    localparam int KW       = $clog2(KER_SIZE);
    localparam int CW       = (NCOLS > 1) ? $clog2(NCOLS) : 1;
    localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic signed [ACC_BITS-1:0] KK_S = ACC_BITS'(KK);

    typedef logic signed [ACC_BITS-1:0] acc_t;

    logic [KW-1:0] h_cnt, v_cnt;
    logic [CW-1:0] col_idx;
    logic [RW-1:0] row;
    logic          frame_mode, cur_mode;
    logic          in_fire, first_px, seg_end, win_done, frame_end;
    acc_t          h_acc   [NFMAPS];
    acc_t          row_buf [NCOLS][NFMAPS];
    acc_t          h_val   [NFMAPS];
    acc_t          v_val   [NFMAPS];
    logic [NBITS*NFMAPS-1:0] result;

    function automatic acc_t sext(input logic signed [NBITS-1:0] v);
        return acc_t'(v);
    endfunction

    function automatic acc_t fold(input logic avg, input acc_t a, input acc_t b);
        if (avg)
            return a + b;
        return (a > b) ? a : b;
    endfunction

    // Division truncates toward zero; step negative non-exact quotients down to get floor.
    function automatic logic [NBITS-1:0] avg_div(input acc_t s);
        acc_t q, r;
        q = s / KK_S;
        r = s - q * KK_S;
        if (r != '0 && s < 0)
            q = q - acc_t'(1);
        return q[NBITS-1:0];
    endfunction

    assign in_ready  = !out_valid || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign first_px  = (h_cnt == '0) && (col_idx == '0) && (row == '0);
    assign cur_mode  = first_px ? mode : frame_mode;
    assign seg_end   = (h_cnt == KW'(KER_SIZE - 1));
    assign win_done  = seg_end && (v_cnt == KW'(KER_SIZE - 1));
    assign frame_end = win_done && (col_idx == CW'(NCOLS - 1)) && (row == RW'(IMG_H - 1));

    always_comb begin
        result = '0;
        for (int i = 0; i < NFMAPS; i++) begin
            h_val[i] = (h_cnt == '0) ? sext(in_act[i*NBITS +: NBITS])
                                     : fold(cur_mode, h_acc[i], sext(in_act[i*NBITS +: NBITS]));
            v_val[i] = (v_cnt == '0) ? h_val[i] : fold(cur_mode, row_buf[col_idx][i], h_val[i]);
            result[i*NBITS +: NBITS] = cur_mode ? avg_div(v_val[i]) : v_val[i][NBITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_cnt      <= '0;
            v_cnt      <= '0;
            col_idx    <= '0;
            row        <= '0;
            frame_mode <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_act    <= '0;
        end else begin
            if (in_fire) begin
                if (first_px)
                    frame_mode <= mode;
                if (seg_end) begin
                    h_cnt <= '0;
                    if (col_idx == CW'(NCOLS - 1)) begin
                        col_idx <= '0;
                        v_cnt   <= (v_cnt == KW'(KER_SIZE - 1)) ? '0 : v_cnt + 1'b1;
                        row     <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
                    end else begin
                        col_idx <= col_idx + 1'b1;
                    end
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
            // A new result may replace one being consumed in the same edge.
            if (in_fire && win_done) begin
                out_valid <= 1'b1;
                out_act   <= result;
                out_last  <= frame_end;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    // Datapath storage is always loaded before use within a frame, so it carries no reset.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int i = 0; i < NFMAPS; i++) begin
                h_acc[i] <= h_val[i];
                if (seg_end && !win_done)
                    row_buf[col_idx][i] <= v_val[i];
            end
        end
    end
endmodule

// File: tb/tb_pool_2d_stream.sv
// Directed bench for pool_2d_stream: a K=2 4x2 instance and a K=3 6x3 instance.
module tb_pool_2d_stream;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic        a_mode, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
    logic [31:0] a_in_act, a_out_act;
    logic        b_mode, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [31:0] b_in_act, b_out_act;

    int errors = 0;
    int checks = 0;
    int av [8];
    int bv [18];

    pool_2d_stream #(.NBITS(8), .NFMAPS(4), .KER_SIZE(2), .IMG_W(4), .IMG_H(2)) dut_a (
        .clk(clk), .rstn(rstn), .mode(a_mode), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_act(a_in_act), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_act(a_out_act), .out_last(a_out_last));

    pool_2d_stream #(.NBITS(8), .NFMAPS(4), .KER_SIZE(3), .IMG_W(6), .IMG_H(3)) dut_b (
        .clk(clk), .rstn(rstn), .mode(b_mode), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_act(b_in_act), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_act(b_out_act), .out_last(b_out_last));

    // Packs ch0=a, ch1=b, ch2=a, ch3=b.
    function automatic logic [31:0] e(input int a, input int b);
        logic [7:0] x, y;
        x = 8'(a);
        y = 8'(b);
        return {y, x, y, x};
    endfunction

    function automatic logic [31:0] px(input int v);
        return e(v, -v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input int v, input logic m);
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_act   = px(v);
        a_mode     = m;
        @(posedge clk);
        #1;
    endtask

    task automatic frame_a(input string tag, input logic m, input logic [31:0] e0, input logic [31:0] e1);
        for (int i = 0; i < 8; i++) begin
            send_a(av[i], m);
            if (i == 2) begin
                @(negedge clk);
                a_in_valid = 1'b0;
                repeat (3) @(posedge clk);
            end
            if (i == 4 || i == 6)
                chk({tag, "_idle"}, a_out_valid, 0);
            if (i == 5) begin
                chk({tag, "_v0"}, a_out_valid, 1);
                chk({tag, "_d0"}, a_out_act, e0);
                chk({tag, "_l0"}, a_out_last, 0);
            end
            if (i == 7) begin
                chk({tag, "_v1"}, a_out_valid, 1);
                chk({tag, "_d1"}, a_out_act, e1);
                chk({tag, "_l1"}, a_out_last, 1);
            end
        end
        @(negedge clk);
        a_in_valid = 1'b0;
    endtask

    task automatic frame_b(input string tag, input logic m0, input logic [31:0] e0, input logic [31:0] e1);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            b_in_valid = 1'b1;
            b_in_act   = px(bv[i]);
            b_mode     = (i < 3) ? m0 : !m0;
            @(posedge clk);
            #1;
            if (i == 13)
                chk({tag, "_idle"}, b_out_valid, 0);
            if (i == 14) begin
                chk({tag, "_v0"}, b_out_valid, 1);
                chk({tag, "_d0"}, b_out_act, e0);
                chk({tag, "_l0"}, b_out_last, 0);
            end
            if (i == 17) begin
                chk({tag, "_v1"}, b_out_valid, 1);
                chk({tag, "_d1"}, b_out_act, e1);
                chk({tag, "_l1"}, b_out_last, 1);
            end
        end
        @(negedge clk);
        b_in_valid = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        a_mode = 1'b0; a_in_valid = 1'b0; a_in_act = '0; a_out_ready = 1'b1;
        b_mode = 1'b0; b_in_valid = 1'b0; b_in_act = '0; b_out_ready = 1'b1;
        #3;
        chk("rst_valid", a_out_valid, 0);
        chk("rst_last", a_out_last, 0);
        chk("rst_act", a_out_act, 0);
        chk("rst_ready", a_in_ready, 1);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_hold", a_out_valid, 0);

        av = '{1, -3, 5, 7, 2, 0, -8, 6};
        frame_a("max1", 1'b0, e(2, 3), e(7, 8));
        frame_a("avg1", 1'b1, e(0, 0), e(2, -3));
        av = '{-1, -2, 3, 3, -1, -1, 3, 4};
        frame_a("avg2", 1'b1, e(-2, 1), e(3, -4));

        av = '{-128, -128, -128, -128, -128, -128, -128, -128};
        frame_a("max_neg", 1'b0, e(-128, -128), e(-128, -128));
        frame_a("avg_neg", 1'b1, e(-128, -128), e(-128, -128));
        av = '{127, 127, 127, 127, 127, 127, 127, 127};
        frame_a("avg_pos", 1'b1, e(127, -127), e(127, -127));

        // Stall a pending result for five cycles with the next beat already offered.
        av = '{1, -3, 5, 7, 2, 0, -8, 6};
        for (int i = 0; i < 6; i++)
            send_a(av[i], 1'b0);
        chk("bp_v0", a_out_valid, 1);
        @(negedge clk);
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_act    = px(av[6]);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_ready", a_in_ready, 0);
            chk("bp_valid", a_out_valid, 1);
            chk("bp_act", a_out_act, e(2, 3));
            chk("bp_last", a_out_last, 0);
        end
        @(negedge clk);
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_drain", a_out_valid, 0);
        send_a(av[7], 1'b0);
        chk("bp_v1", a_out_valid, 1);
        chk("bp_d1", a_out_act, e(7, 8));
        chk("bp_l1", a_out_last, 1);
        @(negedge clk);
        a_in_valid = 1'b0;

        // Reset in the middle of row 1 with a result pending.
        for (int i = 0; i < 6; i++)
            send_a(av[i], 1'b1);
        @(negedge clk);
        a_in_valid = 1'b0;
        #1 rstn = 1'b0;
        #1;
        chk("mid_rst_valid", a_out_valid, 0);
        chk("mid_rst_act", a_out_act, 0);
        chk("mid_rst_ready", a_in_ready, 1);
        #1 rstn = 1'b1;
        av = '{-1, -2, 3, 3, -1, -1, 3, 4};
        frame_a("fresh", 1'b1, e(-2, 1), e(3, -4));

        bv = '{5, -7, 12, 3, 9, -20,
               0, 14, -3, 8, -1, 6,
               -9, 2, 7, 11, 4, -2};
        frame_b("k3_avg", 1'b1, e(2, -3), e(2, -2));
        frame_b("k3_max", 1'b0, e(14, 9), e(11, 20));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pool_2d_stream.md
# pool_2d_stream

Streaming KxK pooling engine for NFMAPS parallel feature maps, stride equal to kernel size. It consumes one pixel (all channels) per handshake in raster order, accumulates windows in a per-column row buffer, and emits one pooled pixel per completed window. It supports max or average mode, selected per frame. It sits between a conv/activation stage and the next layer, and replaces the fixed 2x2, fully-parallel max-pool slice array for feature maps that arrive as a stream.

## Interface
- NBITS, 8, signed activation width per channel
- NFMAPS, 4, channels processed in parallel
- KER_SIZE, 2, window edge K (>=2); stride = K
- IMG_W, 8, input frame width in pixels; multiple of K
- IMG_H, 8, input frame height in pixels; multiple of K
- Derived: ACC_BITS = NBITS + clog2(K*K); NCOLS = IMG_W/K

- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- mode  in  1  0 = max, 1 = average; sampled only when pixel (0,0) of a frame is accepted
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept a pixel
- in_act  in  NBITS*NFMAPS  channel i at [(i+1)*NBITS-1 : i*NBITS], signed
- out_valid  out  1  pooled pixel valid
- out_ready  in  1  downstream accepts
- out_act  out  NBITS*NFMAPS  pooled result, same packing as in_act
- out_last  out  1  qualifies the final pooled pixel of a frame

## Operation
- An input beat is accepted when in_valid && in_ready. Counters track col c (0..IMG_W-1) and row r (0..IMG_H-1), wrapping c then r; frame wraps to (0,0) after (IMG_W-1, IMG_H-1).
- Horizontal stage: per channel, a running register folds K consecutive pixels of one row. The fold is max in max mode and signed sum (ACC_BITS) in average mode. The first pixel of a window segment (c%K==0) loads rather than folds.
- Vertical stage: row buffer of NCOLS entries x NFMAPS x ACC_BITS, indexed j=c/K. When c%K==K-1, the segment result is written to entry j. If r%K==0 it overwrites the entry; otherwise it is folded with the stored value.
- Window complete when c%K==K-1 and r%K==K-1. The folded value goes to the output register instead of the buffer.
- Max result: the largest signed value, passed through unchanged (NBITS). Ties give that same value.
- Average result: floor(sum/(K*K)), rounding toward -inf (e.g. -1.25 -> -2, 2.5 -> 2). The result always fits in NBITS; no saturation is needed.
- Mode is latched into a frame register on acceptance of (0,0). Changes mid-frame are ignored.
- out_last = 1 for the window completing at (IMG_W-1, IMG_H-1).
- Row buffer contents need no reset. Entries are always overwritten before being read within a frame.

## Timing
- Reset values: out_valid=0, out_last=0, out_act=0, in_ready=1, counters=0, latched mode=0.
- in_ready = !out_valid || out_ready. It is combinational and independent of in_valid and of position.
- Latency: out_valid rises the cycle after the beat completing a window is accepted.
- While out_valid && !out_ready: out_act and out_last stay stable, in_ready=0, and no state advances.
- Simultaneous output handshake and window completion: the new result loads the output register in the same edge, so out_valid stays 1. Full throughput is one input per cycle with no bubbles when out_ready=1.
- Asserting rstn mid-frame clears outputs and counters asynchronously. The next accepted beat is (0,0) of a new frame.
- in_valid low: the block holds all state; gaps are allowed anywhere in a frame.

## Test plan
- K=2, W=4, H=2, max, ch0 rows [1,-3,5,7] / [2,0,-8,6] -> outputs 2 then 7. out_last only on 7. Latency is 1 cycle after pixel (1,1) and (3,1).
- Same frame, avg -> 0 (sum 0) then 2 (sum 10). Second frame with all-window values [-1,-2,-1,-1] -> -2 (floor of -1.25).
- NBITS=8 extremes: all -128 in max -> -128. All 127 in avg -> 127. All -128 in avg -> -128. No wrap in the accumulator.
- Backpressure: hold out_ready=0 for 5 cycles with a result pending -> in_ready=0, out_act stable, no beats lost. The full frame output matches the reference model.
- K=3, W=6, H=3, random data, mode toggled after pixel (2,0) -> the whole frame uses the mode latched at (0,0). Two outputs are produced, and out_last is on the second.
- Pulse rstn low mid-row 1, then send a full fresh frame -> no stale output. Results equal the model for the fresh frame only.
